// File: rtl/misr_bist.sv
// misr_bist: parametrised multiple-input signature register with a fixed
// compaction window and a golden-signature compare.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   begin or restart a run (reloads SEED, clears cnt and pass)
//   en      absorb i on this cycle while running
//   i       IN_W-bit response bus, zero-extended into the register
//   golden  expected signature, sampled on the final compaction cycle
//   q       current signature register
//   cnt     enabled cycles consumed in the current run
//   busy    high in RUN
//   done    high in DONE
//   pass    valid while done=1; 1 when the final signature matched golden
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | after reset; q holds SEED until start
// RUN   | compacting i on en=1 cycles; CYCLES enabled cycles per run
// DONE  | signature, cnt and pass frozen until the next start

module misr_bist #(
   parameter int               WIDTH  = 5,
   parameter int               IN_W   = 3,
   parameter logic [WIDTH-1:0] POLY   = 5'b11100,
   parameter logic [WIDTH-1:0] SEED   = 5'b00011,
   parameter int               CYCLES = 31,
   parameter int               CNT_W  = $clog2(CYCLES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             en,
   input  logic [IN_W-1:0]  i,
   input  logic [WIDTH-1:0] golden,
   output logic [WIDTH-1:0] q,
   output logic [CNT_W-1:0] cnt,
   output logic             busy,
   output logic             done,
   output logic             pass
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] e;
   logic [WIDTH-1:0] nxt;
   logic             f;
   logic             last;

   // Bit 0 of POLY is never consulted: stage 0 always takes the feedback.
   always_comb begin
      e      = WIDTH'(i);
      f      = q[WIDTH-1];
      nxt    = '0;
      nxt[0] = f ^ e[0];
      for (int k = 1; k < WIDTH; k++) begin
         nxt[k] = q[k-1] ^ (POLY[k] & f) ^ e[k];
      end
   end

   assign last = (cnt == CNT_W'(CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         q     <= SEED;
         cnt   <= '0;
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         pass  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  q     <= SEED;
                  cnt   <= '0;
                  pass  <= 1'b0;
                  state <= RUN;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               // start outranks en: the data presented with a restart is dropped
               if (start) begin
                  q   <= SEED;
                  cnt <= '0;
               end else if (en) begin
                  q   <= nxt;
                  cnt <= cnt + CNT_W'(1);
                  if (last) begin
                     pass  <= (nxt == golden);
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (start) begin
                  q     <= SEED;
                  cnt   <= '0;
                  pass  <= 1'b0;
                  state <= RUN;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               pass  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_misr_bist.sv
module tb_misr_bist;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // CYCLES=4 instance
   logic       rst4, start4, en4, busy4, done4, pass4;
   logic [2:0] i4;
   logic [4:0] golden4, q4;
   logic [2:0] cnt4;

   // CYCLES=1 instance
   logic       rst1, start1, en1, busy1, done1, pass1;
   logic [2:0] i1;
   logic [4:0] golden1, q1;
   logic [0:0] cnt1;

   // default-parameter instance
   logic       rstd, startd, end_, busyd, doned, passd;
   logic [2:0] id;
   logic [4:0] goldend, qd;
   logic [4:0] cntd;

   misr_bist #(.CYCLES(4)) u4 (
      .clk(clk), .rst(rst4), .start(start4), .en(en4), .i(i4), .golden(golden4),
      .q(q4), .cnt(cnt4), .busy(busy4), .done(done4), .pass(pass4)
   );

   misr_bist #(.CYCLES(1)) u1 (
      .clk(clk), .rst(rst1), .start(start1), .en(en1), .i(i1), .golden(golden1),
      .q(q1), .cnt(cnt1), .busy(busy1), .done(done1), .pass(pass1)
   );

   misr_bist ud (
      .clk(clk), .rst(rstd), .start(startd), .en(end_), .i(id), .golden(goldend),
      .q(qd), .cnt(cntd), .busy(busyd), .done(doned), .pass(passd)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Fixed 5-bit / 3-input MISR, taps on stages 2, 3 and 4.
   function automatic logic [4:0] fixed_misr(input logic [4:0] s, input logic [2:0] d);
      logic [4:0] n;
      n[0] = s[4] ^ d[0];
      n[1] = s[0] ^ d[1];
      n[2] = s[1] ^ s[4] ^ d[2];
      n[3] = s[2] ^ s[4];
      n[4] = s[3] ^ s[4];
      return n;
   endfunction

   // Stand-in block under test: o = 3*x truncated to 5 bits.
   function automatic logic [2:0] cut_resp(input logic [3:0] x);
      logic [4:0] o;
      o = {1'b0, x} + {x, 1'b0};
      return {o[0], o[3] ^ o[2], o[4] ^ o[1]};
   endfunction

   logic [4:0] sig;

   initial begin
      rst4 = 1; start4 = 0; en4 = 0; i4 = '0; golden4 = 5'b01101;
      rst1 = 1; start1 = 0; en1 = 0; i1 = '0; golden1 = 5'b00111;
      rstd = 1; startd = 0; end_ = 0; id = '0; goldend = '0;
      tick(); tick();
      chk("rst_q", 32'(q4), 32'h03);
      chk("rst_cnt", 32'(cnt4), 32'h0);
      chk("rst_busy", 32'(busy4), 32'h0);
      chk("rst_done", 32'(done4), 32'h0);
      chk("rst_pass", 32'(pass4), 32'h0);
      rst4 = 0; rst1 = 0; rstd = 0;

      // zero input, CYCLES=4
      start4 = 1; tick(); start4 = 0;
      chk("z_busy", 32'(busy4), 32'h1);
      en4 = 1; i4 = 3'b000;
      tick(); chk("z_q1", 32'(q4), 32'h06);
      tick(); chk("z_q2", 32'(q4), 32'h0C);
      tick(); chk("z_q3", 32'(q4), 32'h18);
      chk("z_done_early", 32'(done4), 32'h0);
      tick(); chk("z_q4", 32'(q4), 32'h0D);
      chk("z_done", 32'(done4), 32'h1);
      chk("z_pass", 32'(pass4), 32'h1);
      chk("z_cnt", 32'(cnt4), 32'h4);
      chk("z_busy_off", 32'(busy4), 32'h0);
      i4 = 3'b111;
      tick(); chk("z_frozen", 32'(q4), 32'h0D);
      chk("z_cnt_frozen", 32'(cnt4), 32'h4);

      // enable gaps: restart from DONE, en = 1,0,0,1,1,0,1
      en4 = 0; i4 = 0; start4 = 1; tick(); start4 = 0;
      chk("g_restart_q", 32'(q4), 32'h03);
      chk("g_restart_done", 32'(done4), 32'h0);
      chk("g_restart_pass", 32'(pass4), 32'h0);
      en4 = 1; tick(); chk("g_q1", 32'(q4), 32'h06);
      en4 = 0; tick(); tick();
      chk("g_hold_q", 32'(q4), 32'h06);
      chk("g_hold_cnt", 32'(cnt4), 32'h1);
      en4 = 1; tick(); tick();
      chk("g_q3", 32'(q4), 32'h18);
      en4 = 0; tick();
      chk("g_hold2_cnt", 32'(cnt4), 32'h3);
      chk("g_not_done", 32'(done4), 32'h0);
      en4 = 1; tick();
      chk("g_final_q", 32'(q4), 32'h0D);
      chk("g_done7", 32'(done4), 32'h1);

      // restart mid-run at cnt=2, with en=1 and nonzero i that must be dropped
      en4 = 0; start4 = 1; tick(); start4 = 0;
      en4 = 1; tick(); tick();
      chk("r_cnt2", 32'(cnt4), 32'h2);
      start4 = 1; i4 = 3'b101; tick(); start4 = 0; i4 = 0;
      chk("r_seed", 32'(q4), 32'h03);
      chk("r_cnt0", 32'(cnt4), 32'h0);
      chk("r_busy", 32'(busy4), 32'h1);
      tick(); tick(); tick();
      chk("r_not_done3", 32'(done4), 32'h0);
      tick();
      chk("r_done", 32'(done4), 32'h1);
      chk("r_q", 32'(q4), 32'h0D);

      // abort by rst at cnt=3
      en4 = 0; start4 = 1; tick(); start4 = 0;
      en4 = 1; tick(); tick(); tick();
      chk("a_cnt3", 32'(cnt4), 32'h3);
      rst4 = 1; tick(); rst4 = 0;
      chk("a_q", 32'(q4), 32'h03);
      chk("a_cnt", 32'(cnt4), 32'h0);
      chk("a_busy", 32'(busy4), 32'h0);
      tick(); tick(); tick();
      chk("a_no_done", 32'(done4), 32'h0);
      chk("a_idle_q", 32'(q4), 32'h03);
      en4 = 0;

      // CYCLES=1
      start1 = 1; tick(); start1 = 0;
      i1 = 3'b001; en1 = 1; golden1 = 5'b00111; tick();
      chk("s_q", 32'(q1), 32'h07);
      chk("s_done", 32'(done1), 32'h1);
      chk("s_pass", 32'(pass1), 32'h1);
      chk("s_cnt", 32'(cnt1), 32'h1);
      en1 = 0; start1 = 1; tick(); start1 = 0;
      golden1 = 5'b00110; en1 = 1; tick();
      chk("s_done2", 32'(done1), 32'h1);
      chk("s_fail_pass", 32'(pass1), 32'h0);
      en1 = 0;

      // default parameters, 31 vectors from the stand-in block
      sig = 5'b00011;
      for (int v = 0; v < 31; v++) sig = fixed_misr(sig, cut_resp(4'(v)));
      goldend = sig;
      for (int run = 0; run < 2; run++) begin
         startd = 1; tick(); startd = 0;
         end_ = 1;
         for (int v = 0; v < 31; v++) begin
            id = cut_resp(4'(v));
            tick();
            if (v == 29) chk("d_not_done30", 32'(doned), 32'h0);
         end
         end_ = 0;
         chk("d_done", 32'(doned), 32'h1);
         chk("d_q", 32'(qd), 32'(sig));
         chk("d_cnt", 32'(cntd), 32'd31);
         chk("d_pass", 32'(passd), run == 0 ? 32'h1 : 32'h0);
         goldend = sig ^ 5'b00001;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
